// File: rtl/bcd_digit_set_ctrl_if.sv
// Bundle of the button-side inputs, the counter-bank readback and the
// counter-bank control outputs of bcd_digit_set_ctrl.
//   ce, sel_st, clr_st, inc_lvl, dec_lvl : timing tick, event pulses, levels
//   DEC       : counter-bank readback, digit i = DEC[15-4i -: 4]
//   cd_ce, UP : per-digit counter enables and shared count direction
//   digit_sel : one-hot selected digit
//   busy      : a pulse sequence is running
// master = environment driving the controller, slave = the controller.
interface bcd_digit_set_ctrl_if;
    logic        ce;
    logic        sel_st;
    logic        clr_st;
    logic        inc_lvl;
    logic        dec_lvl;
    logic [15:0] DEC;
    logic [3:0]  cd_ce;
    logic        UP;
    logic [3:0]  digit_sel;
    logic        busy;

    modport master (
        output ce, sel_st, clr_st, inc_lvl, dec_lvl, DEC,
        input  cd_ce, UP, digit_sel, busy
    );

    modport slave (
        input  ce, sel_st, clr_st, inc_lvl, dec_lvl, DEC,
        output cd_ce, UP, digit_sel, busy
    );
endinterface

// File: rtl/bcd_digit_set_ctrl.sv
// Digit-set sequencer for a bank of four 4-bit up/down counters.
// Converts button levels/pulses into bursts of per-digit counter enables so
// the bank steps through values to the wanted BCD result (wrap or saturate),
// with hold-to-repeat on inc/dec and a clear-all sequence.
// Ports: clk, rst_n (async, active low), bus (slave modport, see interface).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for clr / sel / inc / dec, busy low
// BURST   | cd_ce of target digit high, r_cnt pulses remaining
// SETTLE  | one quiet clk so DEC shows the final value
// CLR_LD  | clear sequence: load pulse count from DEC digit r_clr_idx
module bcd_digit_set_ctrl #(
    parameter int WRAP    = 1,
    parameter int RPT_DLY = 500,
    parameter int RPT_PER = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_digit_set_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_SETTLE, S_CLR_LD} state_t;

    localparam logic [15:0] LP_DLY = 16'(RPT_DLY);
    localparam logic [15:0] LP_PER = 16'(RPT_PER);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_tgt, w_tgt_nxt;
    logic        r_clr_mode, w_clr_mode_nxt;
    logic [1:0]  r_clr_idx, w_clr_idx_nxt;
    logic        r_up, w_up_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic [3:0]  r_cd_ce;
    logic        r_busy;
    logic [15:0] r_timer, w_timer_nxt;
    logic        r_inc_q, r_dec_q;

    logic        w_inc_only, w_dec_only, w_press, w_held;
    logic        w_inc_ev, w_dec_ev;
    logic [1:0]  w_sel_idx;
    logic [3:0]  w_dig [4];
    logic [3:0]  w_d, w_n;

    assign w_dig[0] = bus.DEC[15:12];
    assign w_dig[1] = bus.DEC[11:8];
    assign w_dig[2] = bus.DEC[7:4];
    assign w_dig[3] = bus.DEC[3:0];

    // Both levels high counts as neither; it also clears the repeat timer.
    assign w_inc_only = bus.inc_lvl & ~bus.dec_lvl;
    assign w_dec_only = bus.dec_lvl & ~bus.inc_lvl;
    assign w_press    = (w_inc_only & ~r_inc_q) | (w_dec_only & ~r_dec_q);
    assign w_held     = (w_inc_only & r_inc_q) | (w_dec_only & r_dec_q);
    // Repeat fires on the tick where the down-counter sits at terminal count 1.
    assign w_inc_ev   = bus.ce & w_inc_only & (~r_inc_q | (r_timer == 16'd1));
    assign w_dec_ev   = bus.ce & w_dec_only & (~r_dec_q | (r_timer == 16'd1));

    always_comb begin
        w_timer_nxt = 16'd0;
        if (w_press) begin
            w_timer_nxt = LP_DLY;
        end else if (w_held) begin
            if (r_timer == 16'd1)
                w_timer_nxt = LP_PER;
            else if (r_timer != 16'd0)
                w_timer_nxt = r_timer - 16'd1;
        end
    end

    always_comb begin
        w_sel_idx = 2'd0;
        case (r_sel)
            4'b0010: w_sel_idx = 2'd1;
            4'b0100: w_sel_idx = 2'd2;
            4'b1000: w_sel_idx = 2'd3;
            default: w_sel_idx = 2'd0;
        endcase
    end

    assign w_d = w_dig[w_sel_idx];

    // Pulse count: 4-bit counters wrap mod 16, so 0-d is the distance up to 0.
    always_comb begin
        w_n = 4'd0;
        if (w_inc_ev) begin
            if (w_d < 4'd9)       w_n = 4'd1;
            else if (w_d == 4'd9) w_n = (WRAP != 0) ? 4'd7 : 4'd0;
            else                  w_n = 4'd0 - w_d;
        end else begin
            if (w_d == 4'd0)      w_n = (WRAP != 0) ? 4'd7 : 4'd0;
            else if (w_d <= 4'd9) w_n = 4'd1;
            else                  w_n = w_d - 4'd9;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tgt_nxt      = r_tgt;
        w_clr_mode_nxt = r_clr_mode;
        w_clr_idx_nxt  = r_clr_idx;
        w_up_nxt       = r_up;
        w_sel_nxt      = r_sel;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_st) begin
                    w_state_nxt    = S_CLR_LD;
                    w_clr_mode_nxt = 1'b1;
                    w_clr_idx_nxt  = 2'd0;
                    w_up_nxt       = 1'b0;
                end else if (bus.sel_st) begin
                    w_sel_nxt = {r_sel[2:0], r_sel[3]};
                end else if (w_inc_ev || w_dec_ev) begin
                    w_up_nxt       = w_inc_ev;
                    w_tgt_nxt      = r_sel;
                    w_cnt_nxt      = w_n;
                    w_clr_mode_nxt = 1'b0;
                    if (w_n != 4'd0)
                        w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1)
                    w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_clr_mode && (r_clr_idx != 2'd3)) begin
                    w_state_nxt   = S_CLR_LD;
                    w_clr_idx_nxt = r_clr_idx + 2'd1;
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_clr_mode_nxt = 1'b0;
                end
            end
            S_CLR_LD: begin
                w_tgt_nxt = 4'b0001 << r_clr_idx;
                w_cnt_nxt = w_dig[r_clr_idx];
                if (w_dig[r_clr_idx] != 4'd0) begin
                    w_state_nxt = S_BURST;
                end else if (r_clr_idx == 2'd3) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_mode_nxt = 1'b0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_tgt      <= 4'd0;
            r_clr_mode <= 1'b0;
            r_clr_idx  <= 2'd0;
            r_up       <= 1'b1;
            r_sel      <= 4'b0001;
            r_cd_ce    <= 4'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tgt      <= w_tgt_nxt;
            r_clr_mode <= w_clr_mode_nxt;
            r_clr_idx  <= w_clr_idx_nxt;
            r_up       <= w_up_nxt;
            r_sel      <= w_sel_nxt;
            // Outputs registered from the next state so they align with it.
            r_cd_ce    <= (w_state_nxt == S_BURST) ? w_tgt_nxt : 4'd0;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 16'd0;
            r_inc_q <= 1'b0;
            r_dec_q <= 1'b0;
        end else if (bus.ce) begin
            r_timer <= w_timer_nxt;
            r_inc_q <= bus.inc_lvl;
            r_dec_q <= bus.dec_lvl;
        end
    end

    assign bus.cd_ce     = r_cd_ce;
    assign bus.UP        = r_up;
    assign bus.digit_sel = r_sel;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_bcd_digit_set_ctrl.sv
module tb_bcd_digit_set_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ce = 0, sel_st = 0, clr_st = 0, inc_lvl = 0, dec_lvl = 0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_val = 16'd0;
    logic [15:0] bank_a = 16'd0, bank_b = 16'd0;

    bcd_digit_set_ctrl_if if_a ();
    bcd_digit_set_ctrl_if if_b ();

    assign if_a.ce = ce;  assign if_a.sel_st = sel_st;  assign if_a.clr_st = clr_st;
    assign if_a.inc_lvl = inc_lvl;  assign if_a.dec_lvl = dec_lvl;  assign if_a.DEC = bank_a;
    assign if_b.ce = ce;  assign if_b.sel_st = sel_st;  assign if_b.clr_st = clr_st;
    assign if_b.inc_lvl = inc_lvl;  assign if_b.dec_lvl = dec_lvl;  assign if_b.DEC = bank_b;

    bcd_digit_set_ctrl #(.WRAP(1), .RPT_DLY(4), .RPT_PER(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    bcd_digit_set_ctrl #(.WRAP(0), .RPT_DLY(4), .RPT_PER(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    function automatic logic [15:0] bank_step(logic [15:0] b, logic [3:0] en, logic up);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (en[i]) r[15-4*i -: 4] = up ? r[15-4*i -: 4] + 4'd1 : r[15-4*i -: 4] - 4'd1;
        return r;
    endfunction

    function automatic int dig(logic [15:0] v, int i);
        return int'(v[15-4*i -: 4]);
    endfunction

    int totA[4], totB[4];
    int busyA = 0, busyB = 0, runA = 0, lastRunA = 0;
    initial for (int i = 0; i < 4; i++) begin totA[i] = 0; totB[i] = 0; end

    always @(posedge clk) begin
        if (ld_en) begin
            bank_a <= ld_val;
            bank_b <= ld_val;
        end else begin
            bank_a <= bank_step(bank_a, if_a.cd_ce, if_a.UP);
            bank_b <= bank_step(bank_b, if_b.cd_ce, if_b.UP);
        end
        for (int i = 0; i < 4; i++) begin
            if (if_a.cd_ce[i]) totA[i] <= totA[i] + 1;
            if (if_b.cd_ce[i]) totB[i] <= totB[i] + 1;
        end
        if (if_a.busy) busyA <= busyA + 1;
        if (if_b.busy) busyB <= busyB + 1;
        if (if_a.cd_ce != 4'd0) runA <= runA + 1;
        else begin
            if (runA != 0) lastRunA <= runA;
            runA <= 0;
        end
    end

    int nchk = 0, nerr = 0;
    int sA[4], sB[4];
    int sbA, sbB;

    task automatic check(string tag, int obs, int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin sA[i] = totA[i]; sB[i] = totB[i]; end
        sbA = busyA;
        sbB = busyB;
    endtask

    task automatic load(logic [15:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
        snap();
    endtask

    task automatic tick();
        @(negedge clk); ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((if_a.busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 1, 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // reset state
        check("rst_cd_ce", int'(if_a.cd_ce), 0);
        check("rst_up", int'(if_a.UP), 1);
        check("rst_sel", int'(if_a.digit_sel), 1);
        check("rst_busy", int'(if_a.busy), 0);
        rst_n = 1'b1;

        // single inc from 3
        load(16'h3000);
        inc_lvl = 1'b1; tick(); inc_lvl = 1'b0; tick();
        check("inc3_pulses", totA[0] - sA[0], 1);
        check("inc3_busy", busyA - sbA, 2);
        check("inc3_val", dig(bank_a, 0), 4);
        check("inc3_up", int'(if_a.UP), 1);
        // single dec from 3
        load(16'h3000);
        dec_lvl = 1'b1; tick(); dec_lvl = 1'b0; tick();
        check("dec3_pulses", totA[0] - sA[0], 1);
        check("dec3_val", dig(bank_a, 0), 2);
        check("dec3_up", int'(if_a.UP), 0);

        // wrap inc 9, both WRAP settings
        load(16'h9000);
        inc_lvl = 1'b1; tick(); inc_lvl = 1'b0; tick(); wait_idle("inc9");
        check("inc9_pulses", totA[0] - sA[0], 7);
        check("inc9_run", lastRunA, 7);
        check("inc9_busy", busyA - sbA, 8);
        check("inc9_val", dig(bank_a, 0), 0);
        check("inc9_nowrap_pulses", totB[0] - sB[0], 0);
        check("inc9_nowrap_busy", busyB - sbB, 0);
        check("inc9_nowrap_val", dig(bank_b, 0), 9);
        // wrap dec 0
        load(16'h0000);
        dec_lvl = 1'b1; tick(); dec_lvl = 1'b0; tick(); wait_idle("dec0");
        check("dec0_pulses", totA[0] - sA[0], 7);
        check("dec0_run", lastRunA, 7);
        check("dec0_val", dig(bank_a, 0), 9);
        check("dec0_up", int'(if_a.UP), 0);
        check("dec0_nowrap_pulses", totB[0] - sB[0], 0);
        check("dec0_nowrap_busy", busyB - sbB, 0);

        // hold-to-repeat: events at ticks 0,4,6,8,10
        load(16'h0000);
        inc_lvl = 1'b1;
        repeat (12) tick();
        inc_lvl = 1'b0; tick(); wait_idle("rpt");
        check("rpt_pulses", totA[0] - sA[0], 5);
        check("rpt_val", dig(bank_a, 0), 5);
        check("rpt_val_b", dig(bank_b, 0), 5);
        // both levels held
        load(16'h0000);
        inc_lvl = 1'b1; dec_lvl = 1'b1;
        repeat (6) tick();
        inc_lvl = 1'b0; dec_lvl = 1'b0; tick();
        check("both_pulses", totA[0] - sA[0], 0);
        check("both_busy", busyA - sbA, 0);

        // clear-all
        load(16'h3091);
        @(negedge clk); clr_st = 1'b1;
        @(negedge clk); clr_st = 1'b0;
        wait_idle("clr");
        check("clr_p0", totA[0] - sA[0], 3);
        check("clr_p1", totA[1] - sA[1], 0);
        check("clr_p2", totA[2] - sA[2], 9);
        check("clr_p3", totA[3] - sA[3], 1);
        check("clr_busy", busyA - sbA, 20);
        check("clr_dec", int'(bank_a), 0);
        check("clr_up", int'(if_a.UP), 0);
        check("clr_sel", int'(if_a.digit_sel), 1);

        // digit select rotation
        begin
            logic [3:0] exp_sel [5];
            exp_sel[0] = 4'b0010; exp_sel[1] = 4'b0100; exp_sel[2] = 4'b1000;
            exp_sel[3] = 4'b0001; exp_sel[4] = 4'b0010;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk); sel_st = 1'b1;
                @(negedge clk); sel_st = 1'b0;
                check($sformatf("sel_%0d", k), int'(if_a.digit_sel), int'(exp_sel[k]));
            end
        end
        // sel_st during a burst is dropped
        load(16'h0900);
        @(negedge clk); ce = 1'b1; inc_lvl = 1'b1;
        @(negedge clk); ce = 1'b0;
        @(negedge clk); sel_st = 1'b1;
        @(negedge clk); sel_st = 1'b0;
        inc_lvl = 1'b0; tick(); wait_idle("selbusy");
        check("selbusy_sel", int'(if_a.digit_sel), 2);
        check("selbusy_p1", totA[1] - sA[1], 7);
        check("selbusy_val", dig(bank_a, 1), 0);
        // later inc hits only the selected digit
        load(16'h1234);
        inc_lvl = 1'b1; tick(); inc_lvl = 1'b0; tick();
        check("selinc_dec", int'(bank_a), 16'h1334);
        check("selinc_others", (totA[0] - sA[0]) + (totA[2] - sA[2]) + (totA[3] - sA[3]), 0);

        // reset in the middle of a burst
        load(16'h0900);
        @(negedge clk); ce = 1'b1; inc_lvl = 1'b1;
        @(negedge clk); ce = 1'b0; inc_lvl = 1'b0;
        check("midrst_pre_cd_ce", int'(if_a.cd_ce), 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cd_ce", int'(if_a.cd_ce), 0);
        check("midrst_up", int'(if_a.UP), 1);
        check("midrst_sel", int'(if_a.digit_sel), 1);
        check("midrst_busy", int'(if_a.busy), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_busy", int'(if_a.busy), 0);
        check("postrst_cd_ce", int'(if_a.cd_ce), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
